// File: rtl/dff_pipe.sv
// dff_pipe
//   WIDTH-bit, DEPTH-stage register pipeline with a valid bit per stage, a clock
//   enable (en=0 stalls every stage), a synchronous flush (clr) and preset (set),
//   and a registered occupancy count. It serves as a generic delay line or
//   retiming stage.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   clr      synchronous flush: data = RESET_VAL, all valid bits cleared
//   set      synchronous preset: data = SET_VAL, all valid bits set
//   en       advance the pipeline one stage (0 = hold)
//   d_valid  qualifier for d, captured into the stage 0 valid bit
//   d        input data, captured into stage 0
//   q_valid  valid bit of the last stage
//   q        data of the last stage
//   count    number of stages currently holding valid data (0..DEPTH)
//
// Synchronous priority is clr > set > en > hold. All outputs come straight
// from registers.
module dff_pipe #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr,
   input  logic                         set,
   input  logic                         en,
   input  logic                         d_valid,
   input  logic [WIDTH-1:0]             d,
   output logic                         q_valid,
   output logic [WIDTH-1:0]             q,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      stage_d = stage_q;
      v_d     = v_q;
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = RESET_VAL;
         end
         v_d = '0;
      end else if (set) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = SET_VAL;
         end
         v_d = '1;
      end else if (en) begin
         // The last stage is overwritten without back-pressure; the consumer
         // must take q whenever q_valid is high on an enabled edge.
         for (int i = DEPTH - 1; i > 0; i--) begin
            stage_d[i] = stage_q[i-1];
            v_d[i]     = v_q[i-1];
         end
         stage_d[0] = d;
         v_d[0]     = d_valid;
      end
   end

   // The count is computed from the next-state valid vector, so the
   // registered count always equals popcount of the registered valid bits.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + CNT_W'(v_d[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
         end
         v_q     <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
         v_q     <= v_d;
         count_q <= count_d;
      end
   end

   assign q       = stage_q[DEPTH-1];
   assign q_valid = v_q[DEPTH-1];
   assign count   = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

   logic       clk;
   logic       reset;
   logic       clr, set, en, d_valid;
   logic [7:0] d;
   logic       q_valid;
   logic [7:0] q;
   logic [2:0] count;

   logic       clr1, set1, en1, d_valid1;
   logic [7:0] d1;
   logic       q_valid1;
   logic [7:0] q1;
   logic       count1;

   int errors = 0;
   int checks = 0;

   dff_pipe #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .clr(clr), .set(set), .en(en),
      .d_valid(d_valid), .d(d), .q_valid(q_valid), .q(q), .count(count)
   );

   dff_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
      .clk(clk), .reset(reset), .clr(clr1), .set(set1), .en(en1),
      .d_valid(d_valid1), .d(d1), .q_valid(q_valid1), .q(q1), .count(count1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] exp_q,
                            input logic exp_v, input logic [2:0] exp_cnt);
      check_val({tag, ".q"}, 32'(q), 32'(exp_q));
      check_val({tag, ".q_valid"}, 32'(q_valid), 32'(exp_v));
      check_val({tag, ".count"}, 32'(count), 32'(exp_cnt));
   endtask

   logic [7:0] lat_d [5];
   logic [2:0] lat_cnt [5];

   initial begin
      reset = 1'b0;
      clr = 0; set = 0; en = 0; d_valid = 0; d = 8'h00;
      clr1 = 0; set1 = 0; en1 = 0; d_valid1 = 0; d1 = 8'h00;
      lat_d   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      lat_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

      #12;
      check_out("reset_init", 8'h00, 1'b0, 3'd0);
      check_val("reset_init.count1", 32'(count1), 32'd0);
      reset = 1'b1;

      // latency: edges 1..5 feed 11..55
      en = 1;
      d_valid = 1;
      for (int k = 0; k < 5; k++) begin
         d = lat_d[k];
         step();
         check_val($sformatf("lat_e%0d.count", k + 1), 32'(count), 32'(lat_cnt[k]));
         if (k < 3) check_val($sformatf("lat_e%0d.q_valid", k + 1), 32'(q_valid), 32'd0);
      end
      check_out("lat_e5", 8'h22, 1'b1, 3'd4);

      // flush, then stall test
      clr = 1; en = 0;
      step();
      clr = 0;
      check_out("clr", 8'h00, 1'b0, 3'd0);
      en = 1; d_valid = 1; d = 8'hA1;
      step();
      check_val("stall_e1.count", 32'(count), 32'd1);
      en = 0; d_valid = 0; d = 8'h00;
      for (int k = 0; k < 3; k++) begin
         step();
         check_val($sformatf("stall_hold%0d.count", k), 32'(count), 32'd1);
         check_val($sformatf("stall_hold%0d.q_valid", k), 32'(q_valid), 32'd0);
      end
      en = 1;
      step();
      step();
      check_val("stall_e6.q_valid", 32'(q_valid), 32'd0);
      step();
      check_out("stall_e7", 8'hA1, 1'b1, 3'd1);

      // bubbles: flush first, then 1,0,1,0
      clr = 1;
      step();
      clr = 0;
      en = 1;
      d = 8'h01; d_valid = 1; step(); check_val("bub_e1.count", 32'(count), 32'd1);
      d = 8'h02; d_valid = 0; step(); check_val("bub_e2.count", 32'(count), 32'd1);
      d = 8'h03; d_valid = 1; step(); check_val("bub_e3.count", 32'(count), 32'd2);
      d = 8'h04; d_valid = 0; step(); check_out("bub_e4", 8'h01, 1'b1, 3'd2);
      d = 8'h00; d_valid = 0;
      step(); check_val("bub_e5.q_valid", 32'(q_valid), 32'd0);
      check_val("bub_e5.q", 32'(q), 32'h02);
      check_val("bub_e5.count", 32'(count), 32'd1);
      step(); check_out("bub_e6", 8'h03, 1'b1, 3'd1);
      step(); check_val("bub_e7.q_valid", 32'(q_valid), 32'd0);
      check_val("bub_e7.count", 32'(count), 32'd0);

      // priority
      d = 8'hAA; d_valid = 1; step();
      d = 8'hBB; d_valid = 1; step();
      check_val("prio_load.count", 32'(count), 32'd2);
      set = 1; clr = 1; en = 1;
      step();
      check_out("prio_clr_set", 8'h00, 1'b0, 3'd0);
      clr = 0; en = 0;
      step();
      check_out("prio_set", 8'hFF, 1'b1, 3'd4);
      set = 1; en = 1; d = 8'h12; d_valid = 0;
      step();
      check_out("prio_set_en", 8'hFF, 1'b1, 3'd4);
      set = 0;

      // async reset mid-clock with full pipeline
      #3;
      reset = 1'b0;
      #1;
      check_out("areset_now", 8'h00, 1'b0, 3'd0);
      en = 1; d_valid = 1; d = 8'h77;
      step();
      check_out("areset_held", 8'h00, 1'b0, 3'd0);
      #2;
      reset = 1'b1;
      step();
      check_out("areset_rel", 8'h00, 1'b0, 3'd1);
      en = 0; d_valid = 0;

      // DEPTH=1 corner
      en1 = 1; d_valid1 = 1; d1 = 8'h5A;
      step();
      check_val("d1_e1.q", 32'(q1), 32'h5A);
      check_val("d1_e1.q_valid", 32'(q_valid1), 32'd1);
      check_val("d1_e1.count", 32'(count1), 32'd1);
      d_valid1 = 0; d1 = 8'h3C;
      step();
      check_val("d1_e2.q", 32'(q1), 32'h3C);
      check_val("d1_e2.q_valid", 32'(q_valid1), 32'd0);
      check_val("d1_e2.count", 32'(count1), 32'd0);
      en1 = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
